reset_sequencer: RTL and testbench

Sequences the design's reset release from the clock manager's DCM lock indications. It synchronises the lock flags into the management clock domain and releases the SRAM-domain reset and the two system-domain resets in a fixed order once every lock has been stable for a programmable time. Any later loss of lock re-asserts all resets and is counted. It sits directly downstream of the clock manager and drives the reset inputs of the SRAM controller and the main pipeline.

---
 rtl/reset_sequencer.sv | 191 +++++++++++++++++++
 tb/tb_reset_sequencer.sv | 219 +++++++++++++++++++++
 2 files changed

// File: rtl/reset_sequencer.sv
// reset_sequencer: releases SRAM and system resets in a fixed order once all
// DCM lock indications have been stable for LOCK_STABLE_CYCLES, and re-asserts
// every reset on any later loss of lock.
//
// Optional build macro: RESET_SEQ_WATCHDOG_EN adds a lock watchdog that pulses
// dcm_reset_request when the locks fail to settle in time. Without it,
// dcm_reset_request is held at 0.
//
// Ports:
//   input_clk          management clock, rising edge
//   reset              asynchronous active-high reset
//   dcm_locked         primary DCM lock (asynchronous)
//   dcm_locked_two     secondary DCM lock (asynchronous)
//   dcm_locked_sram    SRAM DCM lock (asynchronous)
//   sram_reset         active-high reset, SRAM clock domain
//   system_reset       active-high reset, modified_clock domain
//   system_two_reset   active-high reset, modified_clock_two domain
//   ready              high while the sequencer is in RUN
//   lock_lost_count    saturating count of lock losses seen in RUN
//   dcm_reset_request  DCM reset pulse request (watchdog build only)
module reset_sequencer #(
  parameter int unsigned LOCK_STABLE_CYCLES  = 1024,
  parameter int unsigned SRAM_TO_SYS_CYCLES  = 16,
  parameter int unsigned LOCK_TIMEOUT_CYCLES = 50000,
  parameter int unsigned RESET_PULSE_CYCLES  = 10
) (
  input  logic       input_clk,
  input  logic       reset,
  input  logic       dcm_locked,
  input  logic       dcm_locked_two,
  input  logic       dcm_locked_sram,
  output logic       sram_reset,
  output logic       system_reset,
  output logic       system_two_reset,
  output logic       ready,
  output logic [7:0] lock_lost_count,
  output logic       dcm_reset_request
);

  localparam int unsigned CNT_W = 16;
  localparam logic [CNT_W-1:0] STABLE_LAST = CNT_W'(LOCK_STABLE_CYCLES - 1);
  localparam logic [CNT_W-1:0] SYS_LAST    = CNT_W'(SRAM_TO_SYS_CYCLES - 1);

  localparam logic [2:0] ST_WAIT_LOCK = 3'd0;
  localparam logic [2:0] ST_STABLE    = 3'd1;
  localparam logic [2:0] ST_SRAM_REL  = 3'd2;
  localparam logic [2:0] ST_RUN       = 3'd3;
  localparam logic [2:0] ST_FAULT     = 3'd4;

  // Reject configurations the 16-bit counters cannot represent.
  if (LOCK_STABLE_CYCLES < 2 || LOCK_STABLE_CYCLES > 65535) begin : g_bad_stable
    $error("reset_sequencer: LOCK_STABLE_CYCLES out of range");
  end
  if (SRAM_TO_SYS_CYCLES < 1 || SRAM_TO_SYS_CYCLES > 65535) begin : g_bad_sys
    $error("reset_sequencer: SRAM_TO_SYS_CYCLES out of range");
  end
  if (LOCK_TIMEOUT_CYCLES < 1 || LOCK_TIMEOUT_CYCLES > 65535) begin : g_bad_timeout
    $error("reset_sequencer: LOCK_TIMEOUT_CYCLES out of range");
  end
  if (RESET_PULSE_CYCLES < 1 || RESET_PULSE_CYCLES > 65535) begin : g_bad_pulse
    $error("reset_sequencer: RESET_PULSE_CYCLES out of range");
  end

  logic [2:0]       sync_meta;
  logic [2:0]       sync_lock;
  logic             lock_all;
  logic [2:0]       state;
  logic [2:0]       state_next;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] cnt_next;
  logic             from_run;

  // Two-flop synchronisers, one per lock input.
  always_ff @(posedge input_clk or posedge reset) begin
    if (reset) begin
      sync_meta <= 3'b000;
      sync_lock <= 3'b000;
    end else begin
      sync_meta <= {dcm_locked_sram, dcm_locked_two, dcm_locked};
      sync_lock <= sync_meta;
    end
  end

  assign lock_all = &sync_lock;

  // State and shared stable/release counter.
  always_ff @(posedge input_clk or posedge reset) begin
    if (reset) begin
      state <= ST_WAIT_LOCK;
      cnt   <= '0;
    end else begin
      state <= state_next;
      cnt   <= cnt_next;
    end
  end

  // Next-state logic.
  always_comb begin
    state_next = state;
    cnt_next   = '0;
    case (state)
      ST_WAIT_LOCK: begin
        if (lock_all) state_next = ST_STABLE;
      end
      ST_STABLE: begin
        if (!lock_all)               state_next = ST_WAIT_LOCK;
        else if (cnt == STABLE_LAST) state_next = ST_SRAM_REL;
        else                         cnt_next   = cnt + CNT_W'(1);
      end
      ST_SRAM_REL: begin
        if (!lock_all)            state_next = ST_FAULT;
        else if (cnt == SYS_LAST) state_next = ST_RUN;
        else                      cnt_next   = cnt + CNT_W'(1);
      end
      ST_RUN: begin
        if (!lock_all) state_next = ST_FAULT;
      end
      ST_FAULT: begin
        state_next = ST_WAIT_LOCK;
      end
      default: begin
        state_next = ST_WAIT_LOCK;
      end
    endcase
  end

  // Registered outputs decoded from the current state; from_run remembers
  // whether FAULT was reached from RUN so only those losses are counted.
  always_ff @(posedge input_clk or posedge reset) begin
    if (reset) begin
      sram_reset       <= 1'b1;
      system_reset     <= 1'b1;
      system_two_reset <= 1'b1;
      ready            <= 1'b0;
      lock_lost_count  <= 8'd0;
      from_run         <= 1'b0;
    end else begin
      sram_reset       <= !(state == ST_SRAM_REL || state == ST_RUN);
      system_reset     <= (state != ST_RUN);
      system_two_reset <= (state != ST_RUN);
      ready            <= (state == ST_RUN);
      from_run         <= (state == ST_RUN);
      if (state == ST_FAULT && from_run && lock_lost_count != 8'hFF) begin
        lock_lost_count <= lock_lost_count + 8'd1;
      end
    end
  end

`ifdef RESET_SEQ_WATCHDOG_EN
  localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(LOCK_TIMEOUT_CYCLES - 1);
  localparam logic [CNT_W-1:0] PULSE_LAST   = CNT_W'(RESET_PULSE_CYCLES - 1);

  logic [CNT_W-1:0] wd_timer;
  logic [CNT_W-1:0] pulse_cnt;

  // Watchdog: the timer is frozen while a request pulse is in flight, so the
  // request repeats every LOCK_TIMEOUT_CYCLES + RESET_PULSE_CYCLES cycles.
  always_ff @(posedge input_clk or posedge reset) begin
    if (reset) begin
      wd_timer          <= '0;
      pulse_cnt         <= '0;
      dcm_reset_request <= 1'b0;
    end else if (dcm_reset_request) begin
      if (pulse_cnt == PULSE_LAST) begin
        dcm_reset_request <= 1'b0;
        pulse_cnt         <= '0;
        wd_timer          <= '0;
      end else begin
        pulse_cnt <= pulse_cnt + CNT_W'(1);
      end
    end else if (state == ST_WAIT_LOCK || state == ST_STABLE) begin
      if (wd_timer == TIMEOUT_LAST) begin
        dcm_reset_request <= 1'b1;
        pulse_cnt         <= '0;
        wd_timer          <= '0;
      end else begin
        wd_timer <= wd_timer + CNT_W'(1);
      end
    end else begin
      wd_timer <= '0;
    end
  end
`else
  // No watchdog: request output held low.
  always_ff @(posedge input_clk or posedge reset) begin
    if (reset) dcm_reset_request <= 1'b0;
    else       dcm_reset_request <= 1'b0;
  end
`endif

endmodule

// File: tb/tb_reset_sequencer.sv
// Scoreboard bench for reset_sequencer: stimulus pushes the expected output
// vector and the edge at which it must appear; the monitor pops one entry per
// observed output change and compares edge and value.
module tb_reset_sequencer;

  localparam int N = 8;
  localparam int S = 4;
  localparam int T = 100;
  localparam int P = 10;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       l1 = 1'b0;
  logic       l2 = 1'b0;
  logic       l3 = 1'b0;
  logic       sram_reset;
  logic       system_reset;
  logic       system_two_reset;
  logic       ready;
  logic [7:0] lock_lost_count;
  logic       dcm_reset_request;

  reset_sequencer #(
    .LOCK_STABLE_CYCLES (N),
    .SRAM_TO_SYS_CYCLES (S),
    .LOCK_TIMEOUT_CYCLES(T),
    .RESET_PULSE_CYCLES (P)
  ) dut (
    .input_clk        (clk),
    .reset            (rst),
    .dcm_locked       (l1),
    .dcm_locked_two   (l2),
    .dcm_locked_sram  (l3),
    .sram_reset       (sram_reset),
    .system_reset     (system_reset),
    .system_two_reset (system_two_reset),
    .ready            (ready),
    .lock_lost_count  (lock_lost_count),
    .dcm_reset_request(dcm_reset_request)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int          at;
    logic [12:0] v;
  } exp_t;

  exp_t        q[$];
  int          checks = 0;
  int          passes = 0;
  int          lost = 0;
  bit          mon_en = 1'b0;
  logic [12:0] mon_last;
  logic [12:0] mon_cur;

  function automatic logic [12:0] mk(input logic s, input logic sy, input logic sy2,
                                     input logic rd, input logic [7:0] c, input logic rq);
    return {s, sy, sy2, rd, c, rq};
  endfunction

  task automatic chk_int(input string name, input int act, input int exp);
    checks++;
    if (act == exp) passes++;
    else $display("FAIL %s: got %0d expected %0d", name, act, exp);
  endtask

  task automatic chk_vec(input string name, input logic [12:0] act, input logic [12:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
  endtask

  task automatic push(input int at, input logic [12:0] v);
    exp_t e;
    e.at = at;
    e.v  = v;
    q.push_back(e);
  endtask

  // Monitor: every change of the output vector must match the next expectation.
  always @(negedge clk) begin
    if (mon_en) begin
      mon_cur = {sram_reset, system_reset, system_two_reset, ready,
                 lock_lost_count, dcm_reset_request};
      if (mon_cur !== mon_last) begin
        if (q.size() == 0) begin
          checks++;
          $display("FAIL unexpected_change: got %h at cycle %0d, expected %h held",
                   mon_cur, cyc, mon_last);
        end else begin
          exp_t e;
          e = q.pop_front();
          chk_int("event_cycle", cyc, e.at);
          chk_vec("event_value", mon_cur, e.v);
        end
        mon_last = mon_cur;
      end
    end
  end

  task automatic step();
    @(negedge clk);
    #1;
  endtask

  task automatic goto(input int g);
    while (cyc < g) step();
  endtask

  task automatic set_lock(input int which, input logic v);
    case (which)
      0:       l1 = v;
      1:       l2 = v;
      default: l3 = v;
    endcase
  endtask

  // Lose one lock for L cycles while in RUN, then restore; expects the fault
  // three edges later and a fresh release sequence after the restore.
  task automatic drop_restore(input int which, input int len, input bit full);
    int c;
    int r;
    c = cyc;
    set_lock(which, 1'b0);
    lost = (lost < 255) ? lost + 1 : 255;
    push(c + 4, mk(1'b1, 1'b1, 1'b1, 1'b0, 8'(lost), 1'b0));
    goto(c + len);
    set_lock(which, 1'b1);
    r = cyc;
    push(r + N + 4, mk(1'b0, 1'b1, 1'b1, 1'b0, 8'(lost), 1'b0));
    if (full) begin
      push(r + N + S + 4, mk(1'b0, 1'b0, 1'b0, 1'b1, 8'(lost), 1'b0));
      goto(r + N + S + 6);
    end else begin
      goto(r + N + 4);
    end
  endtask

  initial begin
    int c;
    int hi;

    // Reset state while reset is held.
    step();
    step();
    chk_int("rst_sram_reset", int'(sram_reset), 1);
    chk_int("rst_system_reset", int'(system_reset), 1);
    chk_int("rst_system_two_reset", int'(system_two_reset), 1);
    chk_int("rst_ready", int'(ready), 0);
    chk_int("rst_lock_lost_count", int'(lock_lost_count), 0);
    chk_int("rst_dcm_reset_request", int'(dcm_reset_request), 0);
    mon_last = mk(1'b1, 1'b1, 1'b1, 1'b0, 8'd0, 1'b0);
    mon_en   = 1'b1;
    rst      = 1'b0;

    // Basic release: sram_reset at edge N+3, system resets and ready at N+S+3.
    step();
    l1 = 1'b1; l2 = 1'b1; l3 = 1'b1;
    c = cyc;
    push(c + N + 4, mk(1'b0, 1'b1, 1'b1, 1'b0, 8'd0, 1'b0));
    push(c + N + S + 4, mk(1'b0, 1'b0, 1'b0, 1'b1, 8'd0, 1'b0));
    goto(c + N + S + 8);

    // SRAM lock lost for 5 cycles in RUN.
    drop_restore(2, 5, 1'b1);

    // Many losses: count saturates at 255.
    for (int i = 0; i < 260; i++) drop_restore(i % 3, 2, 1'b1);
    chk_int("lost_count_saturated", int'(lock_lost_count), 255);

    // Reset during SRAM_REL.
    drop_restore(0, 2, 1'b0);
    rst = 1'b1;
    push(cyc + 1, mk(1'b1, 1'b1, 1'b1, 1'b0, 8'd0, 1'b0));
    lost = 0;
    #1;
    chk_int("async_sram_reset", int'(sram_reset), 1);
    chk_int("async_lock_lost_count", int'(lock_lost_count), 0);
    chk_int("async_ready", int'(ready), 0);
    step();
    step();
    rst = 1'b0;
    c = cyc;

    // Restart with locks held, plus a 3-cycle dcm_locked_two gap in STABLE.
    goto(c + 5);
    l2 = 1'b0;
    goto(c + 8);
    l2 = 1'b1;
    push(c + 8 + N + 4, mk(1'b0, 1'b1, 1'b1, 1'b0, 8'd0, 1'b0));
    push(c + 8 + N + S + 4, mk(1'b0, 1'b0, 1'b0, 1'b1, 8'd0, 1'b0));
    goto(c + 8 + N + S + 8);

`ifdef RESET_SEQ_WATCHDOG_EN
    // Locks held low: request pulses P wide every T+P cycles.
    c = cyc;
    l1 = 1'b0; l2 = 1'b0; l3 = 1'b0;
    push(c + 4, mk(1'b1, 1'b1, 1'b1, 1'b0, 8'd1, 1'b0));
    hi = c + 4 + T;
    push(hi, mk(1'b1, 1'b1, 1'b1, 1'b0, 8'd1, 1'b1));
    push(hi + P, mk(1'b1, 1'b1, 1'b1, 1'b0, 8'd1, 1'b0));
    push(hi + T + P, mk(1'b1, 1'b1, 1'b1, 1'b0, 8'd1, 1'b1));
    push(hi + T + 2 * P, mk(1'b1, 1'b1, 1'b1, 1'b0, 8'd1, 1'b0));
    goto(hi + T + 2 * P + 5);
`else
    hi = 0;
`endif

    goto(cyc + 5);
    chk_int("pending_expectations", q.size(), hi * 0);
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
